wisc_ex_mem_reg: RTL

- EX/MEM pipeline register that sits directly upstream of the memory-access stage.
- Captures EX-stage results and issues each load/store to the cache as a single-cycle Rd/Wr request.
- Holds its contents and back-pressures EX until the cache reports completion.
- Applies flush and halt so that only valid instructions reach memory.

---
 rtl/wisc_ex_mem_reg.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wisc_ex_mem_reg.sv
// rtl/wisc_ex_mem_reg.sv - EX/MEM pipeline register with single-cycle cache request issue
//
// Purpose:
//   Captures EX-stage results, issues each load/store to the cache as a
//   one-cycle read/write request, and back-pressures EX until the cache
//   reports completion (cache_done) or an error (mem_err). Flush and halt
//   are applied at capture so that only valid instructions reach memory.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   ex_valid, flush           EX holds a real instruction / kill the one being captured
//   ex_*                      EX control and data fields
//   cache_done, mem_err       memory stage completion / error for the current access
//   stall_up                  EX must hold its outputs
//   valid                     stage holds a live instruction
//   mem_read_enable,
//   mem_write_enable          single-cycle cache request strobes
//   halt_out .. reg_write     stored control bits gated by valid
//   PC_offset, alu_result,
//   write_data, write_reg     stored data fields (ungated)
//   err                       sticky memory error
module wisc_ex_mem_reg #(
  parameter int ADDR_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic              ex_halt,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_change_PC,
  input  logic              ex_exception,
  input  logic              ex_exception_return,
  input  logic              ex_reg_write,
  input  logic [ADDR_W-1:0] ex_PC_offset,
  input  logic [ADDR_W-1:0] ex_alu_result,
  input  logic [ADDR_W-1:0] ex_write_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              cache_done,
  input  logic              mem_err,
  output logic              stall_up,
  output logic              valid,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic              halt_out,
  output logic              change_PC,
  output logic              exception,
  output logic              exception_return,
  output logic              reg_write,
  output logic [ADDR_W-1:0] PC_offset,
  output logic [ADDR_W-1:0] alu_result,
  output logic [ADDR_W-1:0] write_data,
  output logic [REG_W-1:0]  write_reg,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state;

  logic halt_q;
  logic change_pc_q;
  logic exception_q;
  logic exception_return_q;
  logic reg_write_q;
  logic rd_q;
  logic wr_q;
  logic flush_pend;
  logic halted;

  logic capture;
  logic flush_eff;
  logic cap_valid;
  logic cap_mem;

  // An access in flight releases the stage on completion or on error.
  assign stall_up  = (state != S_IDLE) & ~cache_done & ~mem_err;
  assign capture   = ~stall_up;
  // A flush seen while stalled is remembered and applied to the next capture.
  assign flush_eff = flush | flush_pend;
  assign cap_valid = ex_valid & ~flush_eff & ~halted;
  assign cap_mem   = cap_valid & (ex_mem_read | ex_mem_write);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      valid              <= 1'b0;
      halt_q             <= 1'b0;
      change_pc_q        <= 1'b0;
      exception_q        <= 1'b0;
      exception_return_q <= 1'b0;
      reg_write_q        <= 1'b0;
      rd_q               <= 1'b0;
      wr_q               <= 1'b0;
      PC_offset          <= '0;
      alu_result         <= '0;
      write_data         <= '0;
      write_reg          <= '0;
      flush_pend         <= 1'b0;
      halted             <= 1'b0;
      err                <= 1'b0;
    end else begin
      if ((state != S_IDLE) && mem_err) begin
        err <= 1'b1;
      end
      if (capture) begin
        valid              <= cap_valid;
        halt_q             <= ex_halt;
        change_pc_q        <= ex_change_PC;
        exception_q        <= ex_exception;
        exception_return_q <= ex_exception_return;
        reg_write_q        <= ex_reg_write;
        rd_q               <= ex_mem_read;
        wr_q               <= ex_mem_write;
        PC_offset          <= ex_PC_offset;
        alu_result         <= ex_alu_result;
        write_data         <= ex_write_data;
        write_reg          <= ex_write_reg;
        flush_pend         <= 1'b0;
        halted             <= halted | (cap_valid & ex_halt);
        state              <= cap_mem ? S_ISSUE : S_IDLE;
      end else begin
        // Stalled: the issued access is never aborted, only the next capture is.
        if (flush) begin
          flush_pend <= 1'b1;
        end
        if (state == S_ISSUE) begin
          state <= S_WAIT;
        end
      end
    end
  end

  // Requests are strobed only in the first cycle of an access; read wins
  // over the illegal read+write encoding.
  assign mem_read_enable  = (state == S_ISSUE) & rd_q;
  assign mem_write_enable = (state == S_ISSUE) & wr_q & ~rd_q;

  assign halt_out         = halt_q & valid;
  assign change_PC        = change_pc_q & valid;
  assign exception        = exception_q & valid;
  assign exception_return = exception_return_q & valid;
  assign reg_write        = reg_write_q & valid;

endmodule
